hvac_plant_arbiter: RTL and testbench
=====================================

HVAC_PLANT_ARBITER -- requirements
Module: hvac_plant_arbiter

Interface
REQ-001 Parameter N_ZONES, default 4, number of zone controllers sharing one heating/cooling plant.
REQ-002 Parameter MIN_RUN, default 8, minimum cycles a grant stays asserted (compressor minimum on-time).
REQ-003 Parameter MAX_RUN, default 32, grant length after which a waiting zone preempts.
REQ-004 Parameter DEAD, default 4, plant-off cycles between any two grants.
REQ-005 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 Port rstn  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-007 Port cool_req  input  N_ZONES  per-zone cooling request, level-sensitive, bit i from zone i's cool output.
REQ-008 Port heat_req  input  N_ZONES  per-zone heating request, level-sensitive.
REQ-009 Port grant  output  N_ZONES  one-hot zone currently served; all-zero when none.
REQ-010 Port plant_cool  output  1  drive shared compressor in cooling mode.
REQ-011 Port plant_heat  output  1  drive shared heater.
REQ-012 Port busy  output  1  high in RUN and DEAD states.

Function
REQ-013 Zone i SHALL be requesting when exactly one of cool_req[i], heat_req[i] is high; both high or both low = not requesting.
REQ-014 FSM SHALL have states IDLE, RUN, DEAD; all outputs registered.
REQ-015 IDLE: if any zone requesting, SHALL pick the first requesting zone searching from rr_ptr+1 upward with wrap, and enter RUN next cycle with grant one-hot on it and mode latched from its request.
REQ-016 Latency from request seen in IDLE to grant/plant output high SHALL be exactly 1 cycle.
REQ-017 rr_ptr SHALL update to the granted zone index on each grant.
REQ-018 RUN: run_cnt SHALL equal cycles grant has been high, 1 in first RUN cycle, saturating at MAX_RUN.
REQ-019 RUN: plant_cool=1 if latched mode cool, else plant_heat=1; never both high.
REQ-020 RUN SHALL exit to DEAD when (run_cnt>=MIN_RUN and granted zone no longer requesting latched mode) or (run_cnt>=MAX_RUN and any other zone requesting).
REQ-021 Request drop or mode flip by granted zone before MIN_RUN SHALL NOT shorten the grant; mode flip counts as drop.
REQ-022 DEAD: grant, plant_cool, plant_heat SHALL be 0 for exactly DEAD cycles, then IDLE; requests ignored during DEAD.
REQ-023 Minimum gap between consecutive grants SHALL therefore be DEAD+1 cycles.
REQ-024 Simultaneous requests SHALL be resolved solely by round-robin order; no zone starves while N_ZONES*(MAX_RUN+DEAD+1) bounds its wait.

Reset
REQ-025 On rstn low: state IDLE, grant 0, plant_cool 0, plant_heat 0, busy 0, run_cnt 0, dead counter 0, rr_ptr N_ZONES-1 (zone 0 first).
REQ-026 Reset asserted mid-RUN or mid-DEAD SHALL force outputs low immediately (asynchronously), no dead time enforced.

Structure
REQ-027 State encoding, mode encoding and default parameter constants SHALL live in shared package hvac_pkg.
REQ-028 Round-robin selection SHALL be sub-module rr_pick (request vector, pointer in; one-hot and index out, combinational).
REQ-029 Counters SHALL be sized $clog2(MAX_RUN+1) and $clog2(DEAD+1).

Verification
REQ-030 Reset, cool_req=0001 for 3 cycles -> grant=0001 and plant_cool=1 for exactly 8 cycles, then 4 cycles all-zero, then IDLE.
REQ-031 heat_req=0100 held 20 cycles, no others -> grant=0100 and plant_heat high 20 cycles (1-cycle lag), released on drop.
REQ-032 cool_req=1111 held forever -> grants 0001,0010,0100,1000,0001 each 32 cycles, gaps of 5 cycles.
REQ-033 Zone 1 granted cool, flips to heat_req at run_cnt=3 -> grant held to run_cnt=8, DEAD, then zone 1 regranted in heat.
REQ-034 cool_req[2] and heat_req[2] both high -> no grant ever issued.
REQ-035 rstn pulsed low at run_cnt=5 -> grant and plant outputs 0 same cycle; after release zone 0 searched first.

Source files
------------

// File: rtl/hvac_pkg.sv
// Shared types and default constants for the HVAC plant arbiter.
// Holds the FSM state encoding, the plant mode encoding and the default parameter values.
package hvac_pkg;

  localparam int DEF_N_ZONES = 4;
  localparam int DEF_MIN_RUN = 8;
  localparam int DEF_MAX_RUN = 32;
  localparam int DEF_DEAD    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } hvac_state_e;

  typedef enum logic {
    MODE_HEAT = 1'b0,
    MODE_COOL = 1'b1
  } hvac_mode_e;

  // A zone index needs at least one bit, even when only one zone exists.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request strictly after ptr_i, with wrap.
// valid_o is high whenever any request bit is set; onehot_o and idx_o are meaningful only then.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    int j;
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    j        = 0;
    // The pointer zone itself is visited last, so a zone just served waits for everyone else.
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!valid_o && req_i[j]) begin
        valid_o     = 1'b1;
        idx_o       = IW'(j);
        onehot_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hvac_plant_arbiter.sv
// Shares one heating/cooling plant among N_ZONES zone controllers with round-robin order,
// a compressor minimum on-time, a preemption limit and a fixed plant-off gap between grants.
module hvac_plant_arbiter
  import hvac_pkg::*;
#(
  parameter int N_ZONES = DEF_N_ZONES,
  parameter int MIN_RUN = DEF_MIN_RUN,
  parameter int MAX_RUN = DEF_MAX_RUN,
  parameter int DEAD    = DEF_DEAD
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [N_ZONES-1:0]             cool_req,
  input  logic [N_ZONES-1:0]             heat_req,
  output logic [N_ZONES-1:0]             grant,
  output logic                           plant_cool,
  output logic                           plant_heat,
  output logic                           busy,
  output logic [1:0]                     state_o,
  output logic [$clog2(MAX_RUN+1)-1:0]   run_cnt_o
);

  localparam int IW = idx_width(N_ZONES);
  localparam int RW = $clog2(MAX_RUN + 1);
  localparam int DW = $clog2(DEAD + 1);

  localparam logic [RW-1:0] MIN_RUN_C = RW'(MIN_RUN);
  localparam logic [RW-1:0] MAX_RUN_C = RW'(MAX_RUN);
  localparam logic [DW-1:0] DEAD_C    = DW'(DEAD);

  hvac_state_e          state_q, state_d;
  hvac_mode_e           mode_q, mode_d;
  logic [N_ZONES-1:0]   grant_q, grant_d;
  logic [IW-1:0]        zone_q, zone_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [RW-1:0]        run_cnt_q, run_cnt_d;
  logic [DW-1:0]        dead_cnt_q, dead_cnt_d;
  logic                 plant_cool_q, plant_cool_d;
  logic                 plant_heat_q, plant_heat_d;
  logic                 busy_q, busy_d;

  // A zone asks for service only when exactly one of its two request lines is high.
  logic [N_ZONES-1:0]   zone_req;
  logic [N_ZONES-1:0]   pick_onehot;
  logic [IW-1:0]        pick_idx;
  logic                 pick_valid;
  hvac_mode_e           pick_mode;
  logic                 keep_req;
  logic                 others_req;
  logic                 release_run;

  assign zone_req = cool_req ^ heat_req;

  rr_pick #(
    .N  (N_ZONES),
    .IW (IW)
  ) u_rr_pick (
    .req_i    (zone_req),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  assign pick_mode = cool_req[pick_idx] ? MODE_COOL : MODE_HEAT;

  // A flip to the opposite mode is treated exactly like dropping the request.
  assign keep_req = (mode_q == MODE_COOL) ? (cool_req[zone_q] & ~heat_req[zone_q])
                                          : (heat_req[zone_q] & ~cool_req[zone_q]);

  assign others_req  = |(zone_req & ~grant_q);
  assign release_run = ((run_cnt_q >= MIN_RUN_C) && !keep_req) ||
                       ((run_cnt_q >= MAX_RUN_C) && others_req);

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    grant_d      = grant_q;
    zone_d       = zone_q;
    rr_ptr_d     = rr_ptr_q;
    run_cnt_d    = run_cnt_q;
    dead_cnt_d   = dead_cnt_q;
    plant_cool_d = plant_cool_q;
    plant_heat_d = plant_heat_q;

    unique case (state_q)
      ST_IDLE: begin
        grant_d      = '0;
        plant_cool_d = 1'b0;
        plant_heat_d = 1'b0;
        run_cnt_d    = '0;
        if (pick_valid) begin
          state_d      = ST_RUN;
          grant_d      = pick_onehot;
          zone_d       = pick_idx;
          rr_ptr_d     = pick_idx;
          mode_d       = pick_mode;
          run_cnt_d    = RW'(1);
          plant_cool_d = (pick_mode == MODE_COOL);
          plant_heat_d = (pick_mode == MODE_HEAT);
        end
      end

      ST_RUN: begin
        if (release_run) begin
          state_d      = ST_DEAD;
          grant_d      = '0;
          plant_cool_d = 1'b0;
          plant_heat_d = 1'b0;
          run_cnt_d    = '0;
          dead_cnt_d   = DW'(1);
        end else if (run_cnt_q < MAX_RUN_C) begin
          run_cnt_d = run_cnt_q + RW'(1);
        end
      end

      ST_DEAD: begin
        grant_d      = '0;
        plant_cool_d = 1'b0;
        plant_heat_d = 1'b0;
        // Requests are deliberately not looked at until the off-time has fully elapsed.
        if (dead_cnt_q >= DEAD_C) begin
          state_d    = ST_IDLE;
          dead_cnt_d = '0;
        end else begin
          dead_cnt_d = dead_cnt_q + DW'(1);
        end
      end

      default: begin
        state_d      = ST_IDLE;
        grant_d      = '0;
        plant_cool_d = 1'b0;
        plant_heat_d = 1'b0;
        run_cnt_d    = '0;
        dead_cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_HEAT;
      grant_q      <= '0;
      zone_q       <= '0;
      rr_ptr_q     <= IW'(N_ZONES - 1);
      run_cnt_q    <= '0;
      dead_cnt_q   <= '0;
      plant_cool_q <= 1'b0;
      plant_heat_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      grant_q      <= grant_d;
      zone_q       <= zone_d;
      rr_ptr_q     <= rr_ptr_d;
      run_cnt_q    <= run_cnt_d;
      dead_cnt_q   <= dead_cnt_d;
      plant_cool_q <= plant_cool_d;
      plant_heat_q <= plant_heat_d;
      busy_q       <= busy_d;
    end
  end

  assign grant      = grant_q;
  assign plant_cool = plant_cool_q;
  assign plant_heat = plant_heat_q;
  assign busy       = busy_q;
  assign state_o    = state_q;
  assign run_cnt_o  = run_cnt_q;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rstn) $onehot0(grant_q));
  a_mode_exclusive: assert property (@(posedge clk) disable iff (!rstn) !(plant_cool_q && plant_heat_q));

endmodule

// File: tb/tb_hvac_plant_arbiter.sv
// Bench for hvac_plant_arbiter: directed scenarios with literal expectations plus a long
// randomized run, all checked every cycle against a zone-level model of the plant schedule.
module tb_hvac_plant_arbiter;
  import hvac_pkg::*;

  localparam int N       = 4;
  localparam int MIN_RUN = 8;
  localparam int MAX_RUN = 32;
  localparam int DEAD    = 4;
  localparam int RW      = $clog2(MAX_RUN + 1);

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  cool_req;
  logic [N-1:0]  heat_req;
  logic [N-1:0]  grant;
  logic          plant_cool;
  logic          plant_heat;
  logic          busy;
  logic [1:0]    state_o;
  logic [RW-1:0] run_cnt_o;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  hvac_plant_arbiter #(
    .N_ZONES (N),
    .MIN_RUN (MIN_RUN),
    .MAX_RUN (MAX_RUN),
    .DEAD    (DEAD)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cool_req   (cool_req),
    .heat_req   (heat_req),
    .grant      (grant),
    .plant_cool (plant_cool),
    .plant_heat (plant_heat),
    .busy       (busy),
    .state_o    (state_o),
    .run_cnt_o  (run_cnt_o)
  );

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time budget (got no end, required end)");
    $fatal(1);
  end

  // ---------------- behavioural model ----------------
  // Who is being served (-1 = nobody), for how long, how many off cycles remain,
  // and which zone was served last (round-robin origin).
  int m_zone = -1;
  int m_len  = 0;
  int m_off  = 0;
  int m_last = N - 1;
  bit m_cool = 1'b0;

  always @(posedge clk or negedge rstn) begin
    int nz, nl, noff, nlast, z;
    bit nc, keep, others;
    if (!rstn) begin
      m_zone <= -1;
      m_len  <= 0;
      m_off  <= 0;
      m_last <= N - 1;
      m_cool <= 1'b0;
    end else begin
      nz = m_zone; nl = m_len; noff = m_off; nlast = m_last; nc = m_cool;
      if (m_zone >= 0) begin
        keep = m_cool ? (cool_req[m_zone] && !heat_req[m_zone])
                      : (heat_req[m_zone] && !cool_req[m_zone]);
        others = 1'b0;
        for (int q = 0; q < N; q++)
          if (q != m_zone && cool_req[q] != heat_req[q]) others = 1'b1;
        if ((m_len >= MIN_RUN && !keep) || (m_len >= MAX_RUN && others)) begin
          nz = -1; nl = 0; noff = DEAD;
        end else if (m_len < MAX_RUN) begin
          nl = m_len + 1;
        end
      end else if (m_off > 0) begin
        noff = m_off - 1;
      end else begin
        for (int k = 1; k <= N; k++) begin
          z = (m_last + k) % N;
          if (nz < 0 && cool_req[z] != heat_req[z]) begin
            nz = z; nc = cool_req[z]; nl = 1; nlast = z;
          end
        end
      end
      m_zone <= nz;
      m_len  <= nl;
      m_off  <= noff;
      m_last <= nlast;
      m_cool <= nc;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [N-1:0]  eg;
    logic          ec, eh, eb;
    logic [1:0]    es;
    logic [RW-1:0] er;
    if (chk_en) begin
      eg = (m_zone >= 0) ? (N'(1) << m_zone) : '0;
      ec = (m_zone >= 0) && m_cool;
      eh = (m_zone >= 0) && !m_cool;
      eb = (m_zone >= 0) || (m_off > 0);
      es = (m_zone >= 0) ? ST_RUN : ((m_off > 0) ? ST_DEAD : ST_IDLE);
      er = RW'(m_len);
      total++;
      if (grant !== eg || plant_cool !== ec || plant_heat !== eh || busy !== eb ||
          state_o !== es || run_cnt_o !== er) begin
        bad++;
        $display("FAIL model_cmp t=%0t grant=%b/%b cool=%b/%b heat=%b/%b busy=%b/%b state=%0d/%0d run_cnt=%0d/%0d (got/exp)",
                 $time, grant, eg, plant_cool, ec, plant_heat, eh, busy, eb, state_o, es, run_cnt_o, er);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    cool_req = '0;
    heat_req = '0;
    rstn     = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // ---------------- scoreboard / stimulus ----------------
  logic [N-1:0] exp_q[$];
  int           gl[$];
  int           gp[$];

  initial begin
    logic [N-1:0] prev;
    int hi, dz, len, gap, act;
    bit seen;

    cool_req = '0;
    heat_req = '0;
    rstn     = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset_grant", grant, 0);
    chk("reset_cool", plant_cool, 0);
    chk("reset_heat", plant_heat, 0);
    chk("reset_busy", busy, 0);
    chk("reset_run_cnt", run_cnt_o, 0);
    chk("reset_state", state_o, ST_IDLE);
    rstn = 1'b1;

    // Short cool request: minimum on-time, then the off gap
    cool_req = 4'b0001;
    hi = 0; dz = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("s030_first_grant", grant, 4'b0001);
        chk("s030_first_cool", plant_cool, 1);
      end
      if (i == 2) cool_req = '0;
      if (grant == 4'b0001 && plant_cool) hi++;
      if (busy && grant == '0) dz++;
    end
    chk("s030_on_cycles", hi, 8);
    chk("s030_dead_cycles", dz, 4);
    chk("s030_idle", state_o, ST_IDLE);

    // Heat request held 20 cycles
    heat_req = 4'b0100;
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) chk("s031_first_heat", plant_heat, 1);
      if (i == 19) heat_req = '0;
      if (i == 20) chk("s031_released", grant, 0);
      if (grant == 4'b0100 && plant_heat && !plant_cool) hi++;
    end
    chk("s031_on_cycles", hi, 20);

    // All zones cooling: round-robin order, MAX_RUN grants, DEAD+1 gaps
    do_reset();
    cool_req = 4'b1111;
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    prev = '0; len = 0; gap = 0; seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (grant != '0) begin
        if (prev == '0) begin
          if (seen) gp.push_back(gap);
          if (exp_q.size() > 0) chk("s032_order", grant, exp_q.pop_front());
          len = 0; seen = 1'b1;
        end
        len++;
      end else begin
        if (prev != '0) begin
          gl.push_back(len);
          gap = 1;
        end else begin
          gap++;
        end
      end
      prev = grant;
    end
    chk("s032_all_grants_seen", exp_q.size(), 0);
    for (int k = 0; k < 5; k++) begin
      act = (gl.size() > k) ? gl[k] : -1;
      chk("s032_grant_len", act, 32);
    end
    for (int k = 0; k < 4; k++) begin
      act = (gp.size() > k) ? gp[k] : -1;
      chk("s032_gap_len", act, 5);
    end

    // Mode flip before MIN_RUN does not shorten the grant
    do_reset();
    cool_req = 4'b0010;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) begin
        chk("s033_run_cnt_at_flip", run_cnt_o, 3);
        cool_req = '0;
        heat_req = 4'b0010;
      end
      if (grant == 4'b0010 && plant_cool) hi++;
      if (i == 13) begin
        chk("s033_regrant", grant, 4'b0010);
        chk("s033_regrant_heat", plant_heat, 1);
        chk("s033_regrant_not_cool", plant_cool, 0);
      end
    end
    chk("s033_cool_cycles", hi, 8);

    // Both request lines high: never a grant
    do_reset();
    cool_req = 4'b0100;
    heat_req = 4'b0100;
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (grant != '0 || busy) hi++;
    end
    chk("s034_no_grant", hi, 0);

    // Saturation of run_cnt while alone
    do_reset();
    cool_req = 4'b1000;
    repeat (40) @(negedge clk);
    chk("sat_run_cnt", run_cnt_o, 32);
    chk("sat_grant_held", grant, 4'b1000);

    // Asynchronous reset mid-run, then zone 0 searched first
    do_reset();
    cool_req = 4'b0001;
    repeat (5) @(negedge clk);
    chk("s035_run_cnt", run_cnt_o, 5);
    #1 rstn = 1'b0;
    #1;
    chk("s035_async_grant", grant, 0);
    chk("s035_async_cool", plant_cool, 0);
    chk("s035_async_busy", busy, 0);
    cool_req = 4'b0011;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("s035_zone0_first", grant, 4'b0001);

    // Randomized traffic, checked every cycle by the model
    cool_req = '0;
    heat_req = '0;
    for (int w = 0; w < 120; w++) begin
      int hold;
      hold = $urandom_range(1, 40);
      for (int z = 0; z < N; z++) begin
        int r;
        r = $urandom_range(0, 9);
        cool_req[z] = (r >= 4 && r <= 6) || (r == 9);
        heat_req[z] = (r >= 7);
      end
      if ($urandom_range(0, 29) == 0) begin
        #2 rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
      end
      repeat (hold) @(negedge clk);
    end

    cool_req = '0;
    heat_req = '0;
    repeat (50) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
